// File: rtl/serial_negator.sv
// rtl/serial_negator.sv - bit-serial pass/one's/two's complement/absolute-value unit
module serial_negator #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              inv;
    logic              ovf_pending;

    logic              accept;
    logic              last_bit;
    logic              bit_b;
    logic              res_bit;
    logic              neg_in;
    logic              inv_init;
    logic              carry_init;

    // Operand setup: invert for one's/two's complement and for negative operands under abs;
    // the +1 of negation enters as the initial carry.
    assign neg_in     = in_data[WIDTH-1];
    assign inv_init   = (mode == 2'b01) || (mode == 2'b10) || ((mode == 2'b11) && neg_in);
    assign carry_init = (mode == 2'b10) || ((mode == 2'b11) && neg_in);

    // Single complement cell: conditional invert followed by a half-adder with the carry.
    assign bit_b    = shreg[0] ^ inv;
    assign res_bit  = bit_b ^ carry;
    assign accept   = in_valid && in_ready;
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath: load on accept, shift LSB-first during RUN, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            inv         <= 1'b0;
            ovf_pending <= 1'b0;
            out_data    <= '0;
            overflow    <= 1'b0;
        end else if (accept) begin
            shreg       <= in_data;
            cnt         <= '0;
            inv         <= inv_init;
            carry       <= carry_init;
            ovf_pending <= carry_init && (in_data == MOST_NEG);
        end else if (state == RUN) begin
            shreg <= {res_bit, shreg[WIDTH-1:1]};
            carry <= bit_b & carry;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                out_data <= {res_bit, shreg[WIDTH-1:1]};
                overflow <= ovf_pending;
            end
        end
    end

endmodule

// File: doc/serial_negator.md
Name: serial_negator

Overview:
Bit-serial, parametrised two's-complement unit, the clocked successor of the team's combinational ripple complementer. It accepts one WIDTH-bit word through a valid/ready handshake and processes it LSB-first, one bit per clock, through a single not/xor/and complement cell with a registered carry. Four modes are supported: pass, one's complement, two's complement and absolute value. Overflow is flagged explicitly; there is no extra result bit. It sits between any producer and consumer in the datapath exercises that need sign conversion at low area.

Parameters:
WIDTH, 6, operand and result width in bits; legal values are WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers in_data/mode
in_ready  output  1  unit can accept; combinational, equal to (state == IDLE)
in_data  input  WIDTH  operand, two's-complement signed
mode  input  2  00 pass, 01 one's complement, 10 two's complement, 11 absolute value
out_valid  output  1  result available; equal to (state == DONE)
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result register
overflow  output  1  result not representable; qualified by out_valid
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register, bit counter, carry, out_data and overflow all cleared to 0.
  - Any in-flight operation is discarded and not resumed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: latch in_data into the shift register and latch mode.
  - Set inv = 1 for mode 01, 10, and for 11 when in_data[WIDTH-1] = 1; otherwise inv = 0.
  - Set carry = 1 for mode 10, and for 11 when in_data[WIDTH-1] = 1; otherwise carry = 0.
  - Set ovf_pending = carry AND (in_data == 1 followed by WIDTH-1 zeros).
  - Clear the counter and go to RUN.
- RUN, once per clock:
  - b = shreg[0] XOR inv.
  - The result bit is b XOR carry; the next carry is b AND carry.
  - Shift the register right, inserting the result bit at the MSB.
  - Increment the counter.
  - When counter == WIDTH-1 at the edge: go to DONE, copy the final shifted value into out_data, and copy ovf_pending into overflow.
- Latency: out_valid rises exactly WIDTH clocks after the acceptance edge.
- DONE:
  - out_valid = 1; out_data and overflow hold stable.
  - On an edge with out_ready = 1, go to IDLE.
  - out_data and overflow keep their last values until the next completion.
- Throughput: one word per WIDTH+2 clocks at best. There is no accept in the same cycle as the output handshake.
- in_valid, in_data and mode are ignored outside IDLE; mode is sampled only at acceptance.
- out_ready is ignored outside DONE.
- Boundary behaviour:
  - Two's complement of 0 gives 0 with overflow 0; the final carry-out is discarded.
  - Two's complement or absolute value of the most negative value gives the same value with overflow 1.
  - Pass and one's complement never set overflow.
  - Absolute value of a non-negative input passes it through unchanged.
- Reset asserted during RUN or DONE returns to IDLE immediately. The first operation after release behaves exactly as after power-up.

Test Plan:
WIDTH=6, mode 10, in_data 000101 -> out_valid exactly 6 clocks after accept, out_data 111011, overflow 0; mode 10 on 000000 -> 000000, overflow 0.

mode 10 on 100000 -> 100000, overflow 1; mode 11 on 100000 -> 100000, overflow 1; mode 01 on 100000 -> 011111, overflow 0.

mode 11 on 110110 -> 001010; mode 11 on 001010 -> 001010; mode 00 on 010011 -> 010011; mode 01 on 000000 -> 111111.

Backpressure: hold out_ready low 5 clocks in DONE while toggling in_valid, in_data and mode -> out_valid stays 1, out_data/overflow stable, in_ready 0, no word accepted; after the out_ready pulse -> in_ready 1 on the next cycle.

Reset: drop rst_n asynchronously mid-RUN after 3 bits -> in_ready 1, out_valid 0, busy 0, out_data 000000 immediately; after release, mode 10 on 000001 -> 111111.

Exhaustive: all 64 inputs x 4 modes back-to-back with random out_ready stalls -> every result and overflow matches the reference model; acceptance and completion counts are equal.
